rf_wb_arbiter: RTL
==================

# rf_wb_arbiter

Write-back arbiter and register scoreboard for the RV32I core's 2-read/1-write register file. It merges the execute-stage and memory-stage (load) write-back streams onto the single register-file write port using a valid/ready handshake and round-robin arbitration. It also tracks which architectural registers have an outstanding write, so the issue stage can detect RAW/WAW hazards. It sits between the execute/memory stages and the register-file write port (`we0`/`wr_addr0`/`wr_din0`).

## Interface
- `XLEN`, 32, data width; must equal the register file's `WIDTH`.
- `NREG`, 32, register count; must equal the register file's `DEPTH`. `AW = $clog2(NREG)`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `flush`  in  1  pipeline flush; clears the scoreboard and blocks grants for that cycle.
- `exe_valid`  in  1  execute result pending.
- `exe_ready`  out  1  execute result accepted this cycle.
- `exe_rd`  in  AW  execute destination register.
- `exe_data`  in  XLEN  execute result.
- `mem_valid`  in  1  load result pending.
- `mem_ready`  out  1  load result accepted this cycle.
- `mem_rd`  in  AW  load destination register.
- `mem_data`  in  XLEN  load result.
- `iss_claim`  in  1  issue stage reserves `iss_rd`.
- `iss_rd`  in  AW  register being reserved.
- `q_rs1`, `q_rs2`  in  AW  hazard query addresses.
- `q_busy1`, `q_busy2`  out  1  queried register has a write outstanding (combinational).
- `we0`  out  1  register-file write enable (registered).
- `wr_addr0`  out  AW  register-file write address (registered).
- `wr_din0`  out  XLEN  register-file write data (registered).
- `sb_err`  out  1  sticky error: a claim was made on an already-pending register.

## Operation
- **Handshake**
  - A transfer on a port occurs at a rising edge where `valid && ready`.
  - `ready` is combinational from the valid inputs, `flush`, `rst` and the arbiter state.
  - A requester must hold its `rd` and `data` stable while `valid` is high and `ready` is low.
- **Arbitration**
  - One grant per cycle, at most.
  - If only one port is valid, that port is granted.
  - If both ports are valid, grant the port not granted last. `last_grant` is a 1-bit register, reset to `mem`, so the first contended grant goes to `exe`.
  - `last_grant` updates only on a completed transfer.
- **No grants**
  - Both `ready` outputs are 0 while `flush=1` or `rst=0`.
- **Write port register**
  - On a transfer, at the next edge: `wr_addr0 <= rd`, `wr_din0 <= data`, `we0 <= (rd != 0)`.
  - Otherwise `we0 <= 0`; `wr_addr0` and `wr_din0` hold their values.
  - A transfer to x0 is accepted and dropped (`we0` stays 0).
- **Scoreboard**
  - `pending[NREG-1:1]` holds one bit per register; bit 0 does not exist and x0 is never busy.
  - `iss_claim` with `iss_rd != 0` sets `pending[iss_rd]`.
  - A transfer with `rd != 0` clears `pending[rd]`.
  - If a set and a clear hit the same register on the same edge, the set wins.
  - A claim on a register whose bit is already 1 sets `sb_err`. `sb_err` is cleared only by reset.
  - `flush` clears all pending bits on that edge. A claim in the same cycle as `flush` is ignored.
- **Queries**
  - `q_busyN = (q_rsN != 0) && pending[q_rsN]`. This uses current state only; there is no forwarding of same-cycle claims.

## Timing
- **Reset values** (`rst=0` at an edge): `we0=0`, `wr_addr0=0`, `wr_din0=0`, `pending=0`, `sb_err=0`, `last_grant=mem`. Combinationally during reset: `exe_ready=0`, `mem_ready=0`.
- **Write latency**
  - Transfer at edge N → `we0=1` during cycle N..N+1.
  - The register file commits on the falling edge inside that cycle.
  - Data is readable from the register file before edge N+1.
- **Scoreboard timing**
  - `pending[rd]` clears at edge N, so `q_busy` drops during cycle N..N+1.
  - This is safe because any read sampled at edge N+1 sees the committed data.
- **Throughput**
  - One write per cycle, sustained.
  - Under continuous contention the two ports alternate, giving each 50%.
- **Reset mid-operation**
  - An in-flight `we0` pulse is cancelled at the reset edge.
  - A requester still holding `valid` through reset is not granted until `rst=1`.

## Test plan
- **Reset**: `rst=0` for 2 cycles with `exe_valid=1`, `mem_valid=1` → `exe_ready=0`, `mem_ready=0`, `we0=0`, `wr_addr0=0`, `wr_din0=0`, `pending=0`.
- **Single write**: `exe_valid=1`, `exe_rd=5`, `exe_data=32'hDEADBEEF` for 1 cycle → `exe_ready=1`; next cycle `we0=1`, `wr_addr0=5`, `wr_din0=32'hDEADBEEF`; the following cycle `we0=0`.
- **Contention**: both ports valid for 4 cycles (exe rd=1, mem rd=2) → grant order exe, mem, exe, mem; `wr_addr0` sequence 1, 2, 1, 2.
- **Scoreboard**:
  - Claim rd=7 → `q_busy1=1` for `q_rs1=7`.
  - Later, mem transfer with rd=7 → `q_busy1=0` the cycle after.
  - Claim rd=7 and a transfer to rd=7 on the same edge → `q_busy1` stays 1.
  - Claim rd=0 → `q_busy1=0` for `q_rs1=0`.
- **Error and x0 drop**:
  - Claim rd=3 twice without a write in between → `sb_err=1` and it stays 1.
  - exe transfer with rd=0 → `exe_ready=1`, `we0` stays 0.
- **Flush**: claim rd=4 and rd=9, then `flush=1` with `exe_valid=1` → `exe_ready=0` that cycle; `q_busy` for 4 and 9 reads 0 the next cycle; the exe transfer completes the cycle after `flush` drops.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the 2R/1W register file, plus the register scoreboard.
// Merges execute and load results onto one registered write port, round-robin under contention.
module rf_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            exe_valid,
  output logic            exe_ready,
  input  logic [AW-1:0]   exe_rd,
  input  logic [XLEN-1:0] exe_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            iss_claim,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   q_rs1,
  input  logic [AW-1:0]   q_rs2,
  output logic            q_busy1,
  output logic            q_busy2,
  output logic            we0,
  output logic [AW-1:0]   wr_addr0,
  output logic [XLEN-1:0] wr_din0,
  output logic            sb_err
);

  localparam int NSB = 1 << AW;

  typedef enum logic {
    GRANT_EXE = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e          last_grant_q, last_grant_d;
  logic            we_q, we_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] wr_din_q, wr_din_d;
  logic [NSB-1:0]  pending_q, pending_d;
  logic            sb_err_q, sb_err_d;

  logic            grant_exe, grant_mem, xfer;
  logic [AW-1:0]   xfer_rd;
  logic [XLEN-1:0] xfer_data;
  logic            claim_ok;

  // Ready is purely combinational so a transfer completes in the cycle it is offered.
  always_comb begin
    grant_exe = 1'b0;
    grant_mem = 1'b0;
    if (rst && !flush) begin
      if (exe_valid && mem_valid) begin
        if (last_grant_q == GRANT_MEM) grant_exe = 1'b1;
        else                           grant_mem = 1'b1;
      end else begin
        grant_exe = exe_valid;
        grant_mem = mem_valid;
      end
    end
  end

  assign exe_ready = grant_exe;
  assign mem_ready = grant_mem;
  assign xfer      = grant_exe | grant_mem;
  assign xfer_rd   = grant_exe ? exe_rd   : mem_rd;
  assign xfer_data = grant_exe ? exe_data : mem_data;
  assign claim_ok  = iss_claim && (iss_rd != '0) && !flush;

  always_comb begin
    last_grant_d = last_grant_q;
    we_d         = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_din_d     = wr_din_q;
    pending_d    = pending_q;
    sb_err_d     = sb_err_q;

    if (xfer) begin
      last_grant_d = grant_exe ? GRANT_EXE : GRANT_MEM;
      we_d         = (xfer_rd != '0);
      wr_addr_d    = xfer_rd;
      wr_din_d     = xfer_data;
    end

    // Clear before set so a same-edge claim keeps the register reserved.
    if (flush) begin
      pending_d = '0;
    end else begin
      if (xfer && (xfer_rd != '0)) pending_d[xfer_rd] = 1'b0;
      if (claim_ok) begin
        pending_d[iss_rd] = 1'b1;
        if (pending_q[iss_rd]) sb_err_d = 1'b1;
      end
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_q <= GRANT_MEM;
      we_q         <= 1'b0;
      wr_addr_q    <= '0;
      wr_din_q     <= '0;
      pending_q    <= '0;
      sb_err_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      wr_addr_q    <= wr_addr_d;
      wr_din_q     <= wr_din_d;
      pending_q    <= pending_d;
      sb_err_q     <= sb_err_d;
    end
  end

  assign q_busy1  = (q_rs1 != '0) && pending_q[q_rs1];
  assign q_busy2  = (q_rs2 != '0) && pending_q[q_rs2];
  assign we0      = we_q;
  assign wr_addr0 = wr_addr_q;
  assign wr_din0  = wr_din_q;
  assign sb_err   = sb_err_q;

endmodule
